mem_access_ctrl: RTL and testbench

// - Upstream sequencer for the 2-entry x 1-bit memory_1bit store. Takes single read/write requests
//   on a valid/ready port and drives the memory's write_enable/address/data_in. Samples its

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/memory_1bit.sv | 21 ++
 rtl/sat_counter.sv | 17 +
 rtl/mem_access_ctrl.sv | 100 ++++++++++
 tb/tb_mem_access_ctrl.sv | 260 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the memory access controller and its bench.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF    = 1;
    localparam int unsigned DATA_W_DEF    = 1;
    localparam int unsigned ERR_CNT_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        VFY  = 3'd2,
        RD   = 3'd3,
        RSP  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response valid-ready bundle between a requester and mem_access_ctrl.
interface mem_access_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/memory_1bit.sv
// Small store: synchronous write, combinational read, no reset so contents survive one.
module memory_1bit #(
    parameter int unsigned ADDR_W = 1,
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[address] <= data_in;
        end
    end

    assign data_out = mem[address];
endmodule

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences single read / write-then-verify requests into memory_1bit and returns one
// response per request; verify mismatches are flagged and counted.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_access_ctrl_if.slave     bus,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_din,
    input  logic [DATA_W-1:0]    mem_dout
);
    state_e            state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              vfy_mismatch;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // mem_din still holds the captured write data while verifying.
    assign vfy_mismatch = (state_q == VFY) && (mem_dout != mem_din);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        mem_addr    <= bus.req_addr;
                        mem_din     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (bus.req_write) begin
                            state_q <= WR;
                            mem_we  <= 1'b1;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                WR: begin
                    mem_we  <= 1'b0;
                    state_q <= VFY;
                end
                VFY: begin
                    rsp_rdata_q <= mem_dout;
                    rsp_err_q   <= vfy_mismatch;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RSP;
                end
                RD: begin
                    rsp_rdata_q <= mem_dout;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RSP;
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    mem_we      <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (vfy_mismatch),
        .count (err_cnt)
    );
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized bench for mem_access_ctrl wired to memory_1bit.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] err_cnt;
    logic       mem_we;
    logic [0:0] mem_addr;
    logic [0:0] mem_din;
    logic [0:0] mem_dout_raw;
    logic [0:0] ctrl_dout;
    logic       inv_en;

    int n_tests = 0;
    int n_fail  = 0;
    int we_total = 0;

    // Reference state: memory contents and expected error count.
    logic [0:0] mem_model [2];
    int         err_model = 0;

    mem_access_ctrl_if bus_if ();

    // Optional corruption of the read path to provoke verify mismatches.
    assign ctrl_dout = inv_en ? ~mem_dout_raw : mem_dout_raw;

    mem_access_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if.slave),
        .err_cnt  (err_cnt),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (ctrl_dout)
    );

    memory_1bit u_mem (
        .clk          (clk),
        .write_enable (mem_we),
        .address      (mem_addr),
        .data_in      (mem_din),
        .data_out     (mem_dout_raw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit wr, input bit [0:0] addr, input bit [0:0] wd, input bit inv,
                       input int stall);
        logic [0:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
        int         cyc;
        int         we_seen;
        bit         got;
        logic [0:0] hold_rdata;
        logic       hold_err;
        if (wr) begin
            mem_model[addr] = wd;
            exp_rdata = inv ? ~wd : wd;
            exp_err   = inv;
            if (inv && err_model < 15) err_model++;
            exp_lat = 3;
        end else begin
            exp_rdata = mem_model[addr];
            exp_err   = 1'b0;
            exp_lat   = 2;
        end
        @(negedge clk);
        check("idle_ready", 32'(bus_if.req_ready), 32'd1);
        inv_en           = inv;
        bus_if.req_valid = 1'b1;
        bus_if.req_write = wr;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wd;
        @(posedge clk);
        cyc = 0;
        we_seen = 0;
        got = 1'b0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus_if.req_valid = 1'b0;
                bus_if.req_wdata = ~wd;
            end
            if (mem_we) we_seen++;
            if (bus_if.rsp_valid) got = 1'b1;
        end
        we_total += we_seen;
        check("latency", got ? 32'(cyc) : 32'd99, 32'(exp_lat));
        check("we_cycles", 32'(we_seen), wr ? 32'd1 : 32'd0);
        check("rsp_rdata", 32'(bus_if.rsp_rdata), 32'(exp_rdata));
        check("rsp_err", 32'(bus_if.rsp_err), 32'(exp_err));
        check("err_cnt", 32'(err_cnt), 32'(err_model));
        hold_rdata = bus_if.rsp_rdata;
        hold_err   = bus_if.rsp_err;
        for (int s = 0; s < stall; s++) begin
            bus_if.req_valid = 1'b1;
            bus_if.req_write = 1'($urandom);
            bus_if.req_addr  = 1'($urandom);
            bus_if.req_wdata = 1'($urandom);
            @(negedge clk);
            check("stall_req_ready", 32'(bus_if.req_ready), 32'd0);
            check("stall_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
            check("stall_rdata", 32'(bus_if.rsp_rdata), 32'(hold_rdata));
            check("stall_err", 32'(bus_if.rsp_err), 32'(hold_err));
        end
        bus_if.req_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
        inv_en = 1'b0;
        check("post_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("post_req_ready", 32'(bus_if.req_ready), 32'd1);
    endtask

    initial begin
        int we_base;
        bit [0:0] a;
        bit [0:0] d;
        bit       seen_rsp;

        rst_n            = 1'b0;
        inv_en           = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.rsp_ready = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            bus_if.req_valid = 1'($urandom);
            bus_if.req_write = 1'($urandom);
            bus_if.req_addr  = 1'($urandom);
            bus_if.req_wdata = 1'($urandom);
            bus_if.rsp_ready = 1'($urandom);
            @(negedge clk);
            check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
            check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_err_cnt", 32'(err_cnt), 32'd0);
        end
        check("rst_rdata", 32'(bus_if.rsp_rdata), 32'd0);
        check("rst_err", 32'(bus_if.rsp_err), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        bus_if.req_valid = 1'b0;
        bus_if.rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Bring memory to a known state, then write 1 to addr 1 and read both back.
        txn(1'b1, 1'b0, 1'b0, 1'b0, 0);
        txn(1'b1, 1'b1, 1'b0, 1'b0, 0);
        txn(1'b1, 1'b1, 1'b1, 1'b0, 0);
        txn(1'b0, 1'b1, 1'b0, 1'b0, 0);
        txn(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Two writes then two reads: exactly two mem_we cycles.
        we_base = we_total;
        txn(1'b1, 1'b0, 1'b0, 1'b0, 0);
        txn(1'b1, 1'b1, 1'b1, 1'b0, 0);
        txn(1'b0, 1'b0, 1'b0, 1'b0, 0);
        txn(1'b0, 1'b1, 1'b0, 1'b0, 0);
        check("we_total_two_writes", 32'(we_total - we_base), 32'd2);

        // Response back-pressure.
        txn(1'b1, 1'b0, 1'b1, 1'b0, 5);
        txn(1'b0, 1'b0, 1'b0, 1'b0, 5);

        // Forced verify mismatches drive the counter into saturation.
        for (int i = 0; i < 20; i++) begin
            txn(1'b1, 1'($urandom), 1'($urandom), 1'b1, 0);
        end
        check("err_cnt_saturated", 32'(err_cnt), 32'd15);

        // Randomized mix.
        for (int i = 0; i < 30; i++) begin
            bit wr;
            wr = 1'($urandom);
            txn(wr, 1'($urandom), 1'($urandom), wr && ($urandom_range(0, 7) == 0),
                $urandom_range(0, 3));
        end

        // Reset during WR: write must not land, no response, outputs drop immediately.
        a = 1'($urandom);
        d = ~mem_model[a];
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b1;
        bus_if.req_addr  = a;
        bus_if.req_wdata = d;
        @(posedge clk);
        #2;
        check("wr_state_mem_we", 32'(mem_we), 32'd1);
        bus_if.req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_we", 32'(mem_we), 32'd0);
        check("async_rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        check("async_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        err_model = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_rsp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid) seen_rsp = 1'b1;
        end
        check("no_rsp_after_rst", 32'(seen_rsp), 32'd0);
        check("err_cnt_cleared", 32'(err_cnt), 32'd0);
        txn(1'b0, a, 1'b0, 1'b0, 0);

        // Reset during VFY: the write has already been clocked into memory.
        a = 1'($urandom);
        d = ~mem_model[a];
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b1;
        bus_if.req_addr  = a;
        bus_if.req_wdata = d;
        @(posedge clk);
        #2;
        bus_if.req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        mem_model[a] = d;
        #1;
        check("vfy_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, a, 1'b0, 1'b0, 0);
        txn(1'b0, ~a, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
